fatori_mon_voter_q: RTL and testbench

Quarantining M-of-N voter: next-generation replacement for the fixed voter used by the fatori_mon_wrap_* replica wrappers. Adds three behaviours to the plain voter:
- bitwise-votes N replica buses of width W;
- tracks consecutive disagreements per replica and removes a persistently faulty replica from the vote;
- requests a scrub of that replica over a req/ack handshake, then readmits it after a probation window.

It sits between the replica array and the wrapper's outward ports, and feeds the wrapper's min/maj/scrub aggregation.

---
 rtl/fatori_mon_voter_q.sv | 197 +++++++++++++++++++
 tb/tb_fatori_mon_voter_q.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fatori_mon_voter_q.sv
// Quarantining M-of-N bitwise voter with per-replica strike/probation tracking and scrub req/ack.
// Latency: vote/errors combinational, state 1 cycle; backpressure: scrub_req_o held until scrub_ack_i.
module fatori_mon_voter_q #(
    parameter int W          = 32,
    parameter int N          = 3,
    parameter int M          = 0,
    parameter int HOLD       = 0,
    parameter int STRIKE_MAX = 3,
    parameter int PROBE_LEN  = 4,
    localparam int IW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [N*W-1:0] replicas_i,
    input  logic           scrub_ack_i,
    output logic [W-1:0]   y_o,
    output logic           min_err_o,
    output logic           maj_err_o,
    output logic [N-1:0]   active_mask_o,
    output logic           scrub_req_o,
    output logic [IW-1:0]  scrub_idx_o,
    output logic           scrub_occurred_o
);

    localparam int         M_EFF = (M == 0) ? (N / 2 + 1) : M;
    localparam logic [3:0] ME4   = 4'(M_EFF);
    localparam logic [3:0] SM4   = 4'(STRIKE_MAX);
    localparam logic [3:0] PL4   = 4'(PROBE_LEN);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_QUAR   = 2'd1,
        ST_SCRUB  = 2'd2,
        ST_PROB   = 2'd3
    } rep_st_t;

    rep_st_t       r_st      [N];
    logic [3:0]    r_cnt     [N];
    rep_st_t       w_st_nxt  [N];
    logic [3:0]    w_cnt_nxt [N];
    logic [W-1:0]  r_last_y;
    logic          r_scrub_req;
    logic [IW-1:0] r_scrub_idx;
    logic          r_scrub_occ;

    logic [N-1:0]  w_act;
    logic [N-1:0]  w_agree;
    logic [3:0]    w_na;
    logic [3:0]    w_agree_cnt;
    logic [W-1:0]  w_vote;
    logic          w_maj;
    logic [N-1:0]  w_q_elig;
    logic [N-1:0]  w_q_pick;
    logic [N-1:0]  w_s_pick;
    logic [IW-1:0] w_s_idx;
    logic          w_ack_acc;

    function automatic logic [3:0] f_pop(input logic [N-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c = c + {3'b000, v[i]};
        return c;
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_act[i]   = (r_st[i] == ST_ACTIVE);
            w_agree[i] = (replicas_i[i*W +: W] == w_vote);
        end
    end

    assign w_na        = f_pop(w_act);
    assign w_agree_cnt = f_pop(w_act & w_agree);
    assign w_maj       = (w_agree_cnt < ME4);

    // Ties (even active count) fall back to the last trusted output bit.
    always_comb begin : p_vote
        logic [3:0] v_ones;
        v_ones = '0;
        w_vote = '0;
        for (int b = 0; b < W; b++) begin
            v_ones = '0;
            for (int i = 0; i < N; i++) v_ones = v_ones + {3'b000, w_act[i] & replicas_i[i*W+b]};
            if ({v_ones, 1'b0} > {1'b0, w_na})       w_vote[b] = 1'b1;
            else if ({v_ones, 1'b0} == {1'b0, w_na}) w_vote[b] = r_last_y[b];
        end
    end

    // Quarantine only while removing one replica keeps the active set at or above M_eff.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_q_elig[i] = !w_maj && w_act[i] && !w_agree[i]
                          && (r_cnt[i] >= SM4 - 4'd1) && (w_na > ME4);
        end
    end

    always_comb begin : p_pick
        logic v_qf;
        logic v_sf;
        w_q_pick = '0;
        w_s_pick = '0;
        w_s_idx  = '0;
        v_qf     = 1'b0;
        v_sf     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_q_elig[i] && !v_qf) begin
                w_q_pick[i] = 1'b1;
                v_qf        = 1'b1;
            end
            if ((r_st[i] == ST_QUAR) && !r_scrub_req && !v_sf) begin
                w_s_pick[i] = 1'b1;
                w_s_idx     = IW'(i);
                v_sf        = 1'b1;
            end
        end
    end

    assign w_ack_acc = scrub_ack_i && r_scrub_req;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_st_nxt[i]  = r_st[i];
            w_cnt_nxt[i] = r_cnt[i];
            case (r_st[i])
                ST_ACTIVE: begin
                    if (!w_maj) begin
                        if (w_agree[i]) begin
                            w_cnt_nxt[i] = '0;
                        end else if (w_q_pick[i]) begin
                            w_st_nxt[i]  = ST_QUAR;
                            w_cnt_nxt[i] = '0;
                        end else if (r_cnt[i] < SM4) begin
                            w_cnt_nxt[i] = r_cnt[i] + 4'd1;
                        end
                    end
                end
                ST_QUAR: begin
                    if (w_s_pick[i]) w_st_nxt[i] = ST_SCRUB;
                end
                ST_SCRUB: begin
                    if (w_ack_acc && (r_scrub_idx == IW'(i))) begin
                        w_st_nxt[i]  = ST_PROB;
                        w_cnt_nxt[i] = '0;
                    end
                end
                default: begin
                    if (!w_maj) begin
                        if (!w_agree[i]) begin
                            w_st_nxt[i]  = ST_QUAR;
                            w_cnt_nxt[i] = '0;
                        end else if (r_cnt[i] >= PL4 - 4'd1) begin
                            w_st_nxt[i]  = ST_ACTIVE;
                            w_cnt_nxt[i] = '0;
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N; i++) begin
                r_st[i]  <= ST_ACTIVE;
                r_cnt[i] <= '0;
            end
            r_last_y    <= '0;
            r_scrub_req <= 1'b0;
            r_scrub_idx <= '0;
            r_scrub_occ <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                r_st[i]  <= w_st_nxt[i];
                r_cnt[i] <= w_cnt_nxt[i];
            end
            if (!w_maj) r_last_y <= w_vote;
            r_scrub_occ <= w_ack_acc;
            if (w_ack_acc) begin
                r_scrub_req <= 1'b0;
            end else if (|w_s_pick) begin
                r_scrub_req <= 1'b1;
                r_scrub_idx <= w_s_idx;
            end
        end
    end

    assign y_o              = ((HOLD != 0) && w_maj) ? r_last_y : w_vote;
    assign maj_err_o        = w_maj;
    assign min_err_o        = !w_maj && (w_agree_cnt < w_na);
    assign active_mask_o    = w_act;
    assign scrub_req_o      = r_scrub_req;
    assign scrub_idx_o      = r_scrub_idx;
    assign scrub_occurred_o = r_scrub_occ;

endmodule

// File: tb/tb_fatori_mon_voter_q.sv
// Directed table-driven bench for fatori_mon_voter_q (N=3, W=8), HOLD=1 and HOLD=0 instances in lockstep.
module tb_fatori_mon_voter_q;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] replicas;
    logic        ack;

    logic [7:0]  y, y0;
    logic        min_err, maj_err, min_err0, maj_err0;
    logic [2:0]  mask, mask0;
    logic        req, req0, occ, occ0;
    logic [1:0]  idx, idx0;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [7:0] r0, r1, r2;
        logic       ack;
        logic [7:0] y;
        logic [7:0] y0;
        logic       min;
        logic       maj;
        logic [2:0] mask;
        logic       req;
        logic [1:0] idx;
        logic       occ;
    } vec_t;

    vec_t tbl[$];

    fatori_mon_voter_q #(.W(8), .N(3), .M(0), .HOLD(1), .STRIKE_MAX(3), .PROBE_LEN(4)) u_dut (
        .clk_i(clk), .rst_i(rst), .replicas_i(replicas), .scrub_ack_i(ack),
        .y_o(y), .min_err_o(min_err), .maj_err_o(maj_err), .active_mask_o(mask),
        .scrub_req_o(req), .scrub_idx_o(idx), .scrub_occurred_o(occ)
    );

    fatori_mon_voter_q #(.W(8), .N(3), .M(0), .HOLD(0), .STRIKE_MAX(3), .PROBE_LEN(4)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .replicas_i(replicas), .scrub_ack_i(ack),
        .y_o(y0), .min_err_o(min_err0), .maj_err_o(maj_err0), .active_mask_o(mask0),
        .scrub_req_o(req0), .scrub_idx_o(idx0), .scrub_occurred_o(occ0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2, input logic a);
        replicas = {r2, r1, r0};
        ack      = a;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        // r0, r1, r2, ack, y(HOLD=1), y(HOLD=0), min, maj, mask, req, idx, occ
        tbl.push_back('{8'hFF, 8'hF0, 8'h0F, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 3'b111, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{8'hA5, 8'hA5, 8'hA5, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0, 3'b111, 1'b0, 2'd0, 1'b0});
        for (int k = 0; k < 2; k++)
            tbl.push_back('{8'hA5, 8'h00, 8'hA5, 1'b0, 8'hA5, 8'hA5, 1'b1, 1'b0, 3'b111, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{8'hA5, 8'hA5, 8'hA5, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0, 3'b111, 1'b0, 2'd0, 1'b0});
        for (int k = 0; k < 3; k++)
            tbl.push_back('{8'hA5, 8'hA5, 8'hFF, 1'b0, 8'hA5, 8'hA5, 1'b1, 1'b0, 3'b111, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{8'hA5, 8'hA5, 8'hFF, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0, 3'b011, 1'b0, 2'd0, 1'b0});
        for (int k = 0; k < 5; k++)
            tbl.push_back('{8'hA5, 8'hA5, 8'hFF, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0, 3'b011, 1'b1, 2'd2, 1'b0});
        tbl.push_back('{8'hA5, 8'hA5, 8'hFF, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b0, 3'b011, 1'b1, 2'd2, 1'b0});
        tbl.push_back('{8'hA5, 8'hA5, 8'hA5, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0, 3'b011, 1'b0, 2'd2, 1'b1});
        for (int k = 0; k < 3; k++)
            tbl.push_back('{8'hA5, 8'hA5, 8'hA5, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0, 3'b011, 1'b0, 2'd2, 1'b0});
        tbl.push_back('{8'hA5, 8'hA5, 8'hA5, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b0, 3'b111, 1'b0, 2'd2, 1'b0});
        for (int k = 0; k < 3; k++)
            tbl.push_back('{8'hA5, 8'hA5, 8'hFF, 1'b0, 8'hA5, 8'hA5, 1'b1, 1'b0, 3'b111, 1'b0, 2'd2, 1'b0});
        tbl.push_back('{8'hA5, 8'hA5, 8'hFF, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0, 3'b011, 1'b0, 2'd2, 1'b0});
        for (int k = 0; k < 4; k++)
            tbl.push_back('{8'hA5, 8'h00, 8'hFF, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b1, 3'b011, 1'b1, 2'd2, 1'b0});
        tbl.push_back('{8'h11, 8'h22, 8'hFF, 1'b0, 8'hA5, 8'h21, 1'b0, 1'b1, 3'b011, 1'b1, 2'd2, 1'b0});
        tbl.push_back('{8'hA5, 8'hA5, 8'hFF, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0, 3'b011, 1'b1, 2'd2, 1'b0});

        rst = 1'b1;
        drive(8'hA5, 8'hA5, 8'hA5, 1'b0);
        #3;
        chk("rst_mask", 32'(mask), 32'(3'b111));
        chk("rst_req", 32'(req), 32'(1'b0));
        chk("rst_idx", 32'(idx), 32'(2'd0));
        chk("rst_occ", 32'(occ), 32'(1'b0));
        chk("rst_y", 32'(y), 32'(8'hA5));
        #5 rst = 1'b0;

        foreach (tbl[k]) begin
            @(negedge clk);
            drive(tbl[k].r0, tbl[k].r1, tbl[k].r2, tbl[k].ack);
            #2;
            chk($sformatf("row%0d_y", k),    32'(y),       32'(tbl[k].y));
            chk($sformatf("row%0d_y0", k),   32'(y0),      32'(tbl[k].y0));
            chk($sformatf("row%0d_min", k),  32'(min_err), 32'(tbl[k].min));
            chk($sformatf("row%0d_maj", k),  32'(maj_err), 32'(tbl[k].maj));
            chk($sformatf("row%0d_mask", k), 32'(mask),    32'(tbl[k].mask));
            chk($sformatf("row%0d_req", k),  32'(req),     32'(tbl[k].req));
            chk($sformatf("row%0d_idx", k),  32'(idx),     32'(tbl[k].idx));
            chk($sformatf("row%0d_occ", k),  32'(occ),     32'(tbl[k].occ));
        end

        // Reset in the middle of a scrub, with ack held: request drops at once, no pulse follows.
        @(negedge clk);
        ack = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(req), 32'(1'b0));
        chk("mid_rst_mask", 32'(mask), 32'(3'b111));
        chk("mid_rst_occ", 32'(occ), 32'(1'b0));
        @(posedge clk);
        #1;
        chk("mid_rst_occ_edge", 32'(occ), 32'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        drive(8'h5A, 8'hA5, 8'hA5, 1'b0);
        #2;
        chk("post_rst_occ", 32'(occ), 32'(1'b0));
        chk("post_rst_req", 32'(req), 32'(1'b0));
        chk("post_rst_min", 32'(min_err), 32'(1'b1));

        // Replica 0 faults from reset: quarantine on 3rd edge, request on 4th.
        cyc = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (req) begin
                cyc = c;
                break;
            end
        end
        chk("q0_req_latency", 32'(cyc), 32'd4);
        chk("q0_idx", 32'(idx), 32'(2'd0));
        chk("q0_mask", 32'(mask), 32'(3'b110));
        chk("q0_min", 32'(min_err), 32'(1'b0));
        chk("q0_y", 32'(y), 32'(8'hA5));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
